bus_arbiter_rr: RTL

- Round-robin arbiter for the shared processor bus. It arbitrates among up to NUM_REQ masters: iCache, dCache, DMA and CI masters.
- Drives one-hot grants and holds the grant from transaction begin through end or error.
- Adds a dead cycle between owners.
- Optional watchdog aborts stuck transactions by asserting a bus error.
- Sits between the requester request lines (iCacheReqBus, dCacheReqBus, ...) and their busAccessGranted inputs.

---
 rtl/bus_arbiter_rr.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared processor bus: registered one-hot grants, a dead cycle between owners.
// Define BUS_ARBITER_WATCHDOG_EN to add the stuck-transaction watchdog that aborts via busErrorOut.

module bus_arbiter_rr #(
  parameter int NUM_REQ         = 4,
  parameter int IDX_WIDTH       = 2,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                 cpuClock,
  input  logic                 cpuReset,
  input  logic [NUM_REQ-1:0]   busRequests,
  output logic [NUM_REQ-1:0]   busGrants,
  input  logic                 beginTransactionIn,
  input  logic                 endTransactionIn,
  input  logic                 dataValidIn,
  input  logic                 busErrorIn,
  output logic                 busErrorOut,
  output logic [IDX_WIDTH-1:0] ownerIndex,
  output logic                 busIdle
);

  typedef enum logic [1:0] {IDLE, GRANTED, BUSY} state_t;

  localparam int SUM_WIDTH = IDX_WIDTH + 1;

  state_t               state, next_state;
  logic [IDX_WIDTH-1:0] ptr, next_ptr, next_owner, winner;
  logic [NUM_REQ-1:0]   next_grants;
  logic [SUM_WIDTH-1:0] scan_sum;
  logic                 found, release_now, abort;

  // First requester at or above the pointer, wrapping modulo NUM_REQ (which need not be a power of two).
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_sum = {1'b0, ptr} + SUM_WIDTH'(i);
      if (scan_sum >= SUM_WIDTH'(NUM_REQ))
        scan_sum = scan_sum - SUM_WIDTH'(NUM_REQ);
      if (!found && busRequests[scan_sum[IDX_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = scan_sum[IDX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    next_state  = state;
    next_ptr    = ptr;
    next_grants = busGrants;
    next_owner  = ownerIndex;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          next_state          = GRANTED;
          next_grants         = '0;
          next_grants[winner] = 1'b1;
          next_owner          = winner;
        end
      end
      GRANTED: begin
        if (beginTransactionIn)
          next_state = BUSY;
        else if (!busRequests[ownerIndex])
          release_now = 1'b1;
      end
      BUSY: begin
        if (endTransactionIn || busErrorIn)
          release_now = 1'b1;
      end
      default: next_state = IDLE;
    endcase

    if (abort)
      release_now = 1'b1;

    // Release never grants in the same edge, which creates the dead cycle between owners.
    if (release_now) begin
      next_state  = IDLE;
      next_grants = '0;
      next_owner  = '0;
      next_ptr    = (ownerIndex == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : ownerIndex + 1'b1;
    end
  end

  always_ff @(posedge cpuClock or posedge cpuReset) begin
    if (cpuReset) begin
      state      <= IDLE;
      ptr        <= '0;
      busGrants  <= '0;
      ownerIndex <= '0;
    end else begin
      state      <= next_state;
      ptr        <= next_ptr;
      busGrants  <= next_grants;
      ownerIndex <= next_owner;
    end
  end

  assign busIdle = (state == IDLE);

`ifdef BUS_ARBITER_WATCHDOG_EN
  localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);

  logic [15:0] wd_count;
  logic        activity;

  assign activity = beginTransactionIn | dataValidIn | endTransactionIn;
  assign abort    = (state != IDLE) && !activity && (wd_count == WD_LAST);

  // Counter saturates at WD_LAST; the abort releases ownership, which clears it again.
  always_ff @(posedge cpuClock or posedge cpuReset) begin
    if (cpuReset) begin
      wd_count    <= '0;
      busErrorOut <= 1'b0;
    end else begin
      busErrorOut <= abort;
      if (state == IDLE || activity || release_now)
        wd_count <= '0;
      else if (wd_count != WD_LAST)
        wd_count <= wd_count + 16'd1;
    end
  end
`else
  logic unused_wd;

  assign abort       = 1'b0;
  assign busErrorOut = 1'b0;
  assign unused_wd   = dataValidIn ^ (WATCHDOG_CYCLES != 0);
`endif

endmodule
